// File: rtl/msb_pkg.sv
// Shared constants and FSM state type for the transmitter block.
// Holds the default word width, the word counter width and the IDLE/RUN/STALL encoding.
package msb_pkg;
    localparam int DW_IN_DEF = 512;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } tx_state_t;
endpackage

// File: rtl/transmitter_if.sv
// Upstream valid/ready bus plus receiver-side outputs of the transmitter.
// The msb_idx/msb_zero signals exist only when TRANSMITTER_MSB_EN is defined.
interface transmitter_if import msb_pkg::*; #(
    parameter int DW_IN = DW_IN_DEF
);
    logic                       s_valid;
    logic                       s_ready;
    logic [DW_IN-1:0]           s_data;
    logic                       enable;
    logic [DW_IN-1:0]           data;
    logic                       data_valid;
    logic [CNT_W-1:0]           word_cnt;
`ifdef TRANSMITTER_MSB_EN
    logic [$clog2(DW_IN)-1:0]   msb_idx;
    logic                       msb_zero;

    modport master (output s_valid, s_data, enable,
                    input  s_ready, data, data_valid, word_cnt, msb_idx, msb_zero);
    modport slave  (input  s_valid, s_data, enable,
                    output s_ready, data, data_valid, word_cnt, msb_idx, msb_zero);
`else
    modport master (output s_valid, s_data, enable,
                    input  s_ready, data, data_valid, word_cnt);
    modport slave  (input  s_valid, s_data, enable,
                    output s_ready, data, data_valid, word_cnt);
`endif
endinterface

// File: rtl/tx_fifo.sv
// Purpose: power-of-two circular word buffer with push/pop/full/empty/count.
// Latency: pushed word visible on pop_data the edge after the push (read is combinational).
// Backpressure: caller must not push when full or pop when empty.
module tx_fifo #(
    parameter int DW_IN = 512,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW_IN-1:0]           push_data,
    input  logic                       pop,
    output logic [DW_IN-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW_IN-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    assign pop_data = mem[rptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
endmodule

// File: rtl/transmitter.sv
// Purpose: buffers upstream words and drives one registered word per clock while enabled.
// Latency: word accepted into an empty buffer appears on data one edge later; s_ready drops when buffer full.
// Optional TRANSMITTER_MSB_EN adds registered msb_idx/msb_zero aligned with data.
module transmitter import msb_pkg::*; #(
    parameter int DW_IN = DW_IN_DEF,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    transmitter_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_t          state, state_nxt;
    logic               push, pop, full, empty, init_done, nonempty_nxt;
    logic [DW_IN-1:0]   fifo_dout;
    logic [CW-1:0]      count;
    logic [DW_IN-1:0]   data_q;
    logic               data_valid_q;
    logic [CNT_W-1:0]   word_cnt_q;

    tx_fifo #(.DW_IN(DW_IN), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.s_data),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // s_ready stays low through reset and rises on the first edge after release.
    assign bus.s_ready = init_done && !full;
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = bus.enable && !empty;
    assign nonempty_nxt = push || (count > CW'(pop));

    always_comb begin
        state_nxt = state;
        if (!bus.enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = nonempty_nxt ? RUN : STALL;
                RUN:     if (!nonempty_nxt) state_nxt = STALL;
                STALL:   if (push) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            init_done    <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            state        <= state_nxt;
            init_done    <= 1'b1;
            data_valid_q <= pop;
            if (pop) begin
                data_q     <= fifo_dout;
                word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.word_cnt   = word_cnt_q;

`ifdef TRANSMITTER_MSB_EN
    localparam int IW = $clog2(DW_IN);

    logic [IW-1:0] msb_nxt, msb_idx_q;
    logic          msb_zero_q;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        msb_nxt = '0;
        for (int i = 0; i < DW_IN; i++) begin
            if (fifo_dout[i]) msb_nxt = IW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_idx_q  <= '0;
            msb_zero_q <= 1'b1;
        end else if (pop) begin
            msb_idx_q  <= msb_nxt;
            msb_zero_q <= (fifo_dout == '0);
        end
    end

    assign bus.msb_idx  = msb_idx_q;
    assign bus.msb_zero = msb_zero_q;
`endif
endmodule
